// File: rtl/lut_neuron_loader_if.sv
// Config stream and lookup bus of the runtime-loadable LUT neuron.
// Readback ports exist only when LUT_READBACK_EN is defined.
interface lut_neuron_loader_if #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_last;
    logic                cfg_err;
    logic                loaded;
    logic                in_valid;
    logic [IN_BITS-1:0]  M0;
    logic                out_valid;
    logic [OUT_BITS-1:0] M1;
`ifdef LUT_READBACK_EN
    logic [IN_BITS-1:0]  rb_addr;
    logic [OUT_BITS-1:0] rb_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last,
        output in_valid, M0, rb_addr,
        input  cfg_ready, cfg_err, loaded, out_valid, M1, rb_data
    );
    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last,
        input  in_valid, M0, rb_addr,
        output cfg_ready, cfg_err, loaded, out_valid, M1, rb_data
    );
`else
    modport master (
        output cfg_start, cfg_valid, cfg_data, cfg_last,
        output in_valid, M0,
        input  cfg_ready, cfg_err, loaded, out_valid, M1
    );
    modport slave (
        input  cfg_start, cfg_valid, cfg_data, cfg_last,
        input  in_valid, M0,
        output cfg_ready, cfg_err, loaded, out_valid, M1
    );
`endif
endinterface

// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron: streamed table load, registered lookup.
// Optional LUT_READBACK_EN adds a registered second read port for verification.
module lut_neuron_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    lut_neuron_loader_if.slave bus
);
    localparam int DEPTH = 1 << IN_BITS;
    localparam logic [IN_BITS:0] LAST_ADDR = (IN_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t              state;
    state_t              state_nx;
    logic [IN_BITS:0]    addr;
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic                beat;
    logic                lookup;
    logic                at_end;
    logic                load_done;
    logic                load_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.cfg_start) begin
            state_nx = LOAD;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_done)     state_nx = RUN;
                    else if (load_bad) state_nx = EMPTY;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        bus.cfg_ready = (state == LOAD);
        bus.loaded    = (state == RUN);
        beat      = (state == LOAD) && bus.cfg_valid && !bus.cfg_start;
        lookup    = (state == RUN) && bus.in_valid && !bus.cfg_start;
        at_end    = (addr == LAST_ADDR);
        load_done = beat && at_end && bus.cfg_last;
        load_bad  = beat && (at_end != bus.cfg_last);
    end

    // Length mismatch is flagged on the offending beat and held until restart
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr        <= '0;
            bus.cfg_err <= 1'b0;
        end else if (bus.cfg_start) begin
            addr        <= '0;
            bus.cfg_err <= 1'b0;
        end else if (beat) begin
            addr <= (at_end || bus.cfg_last) ? '0 : addr + 1'b1;
            if (load_bad) bus.cfg_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (beat) mem[addr[IN_BITS-1:0]] <= bus.cfg_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.M1        <= '0;
        end else begin
            bus.out_valid <= lookup;
            if (lookup) bus.M1 <= mem[bus.M0];
        end
    end

`ifdef LUT_READBACK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.rb_data <= '0;
        else     bus.rb_data <= mem[bus.rb_addr];
    end
`endif
endmodule

// File: tb/tb_lut_neuron_loader.sv
// Self-checking bench for lut_neuron_loader: load, error, lookup, reset.
// Expected table contents come from a plain array model of the written data.
module tb_lut_neuron_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [1:0] pat [64];
    logic [1:0] ref_tbl [64];

    lut_neuron_loader_if #(.IN_BITS(6), .OUT_BITS(2)) bus ();

    lut_neuron_loader #(.IN_BITS(6), .OUT_BITS(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input int n, input int last_idx,
                              input bit gaps, output int cycles,
                              output bit early);
        int  i;
        bit  v;
        bit  rdy;
        i = 0;
        cycles = 0;
        early = 0;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        while (i < n && cycles < 1000) begin
            v = gaps ? (cycles % 2 == 0) : 1'b1;
            bus.cfg_valid = v;
            bus.cfg_data  = pat[i];
            bus.cfg_last  = (i == last_idx);
            rdy = bus.cfg_ready;
            tick();
            cycles++;
            if (v && rdy) i++;
            if (i < n && bus.loaded) early = 1;
        end
        bus.cfg_valid = 1'b0;
        bus.cfg_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({bus.cfg_ready, bus.cfg_err, bus.loaded, bus.out_valid, bus.M1} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b exp 000000",
                     {bus.cfg_ready, bus.cfg_err, bus.loaded, bus.out_valid, bus.M1});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_load();
        int cyc;
        bit early;
        logic [5:0] a [3];
        logic [1:0] e [3];
        a = '{6'd0, 6'd5, 6'd63};
        e = '{2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 64; i++) pat[i] = 2'(i);
        drive_load(64, 63, 0, cyc, early);
        for (int i = 0; i < 64; i++) ref_tbl[i] = pat[i];
        tests++;
        if (bus.loaded !== 1'b1 || bus.cfg_err !== 1'b0 || early) begin
            fails++;
            $display("FAIL full_load got loaded=%b err=%b early=%b exp 1 0 0",
                     bus.loaded, bus.cfg_err, early);
        end
        tests++;
        if (cyc !== 64) begin
            fails++;
            $display("FAIL full_load_cycles got %0d exp 64", cyc);
        end
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.M0 = a[k];
            tick();
            bus.in_valid = 1'b0;
            tests++;
            if (bus.out_valid !== 1'b1 || bus.M1 !== e[k]) begin
                fails++;
                $display("FAIL lookup_%0d got v=%b M1=%b exp 1 %b",
                         a[k], bus.out_valid, bus.M1, e[k]);
            end
            tick();
            tests++;
            if (bus.out_valid !== 1'b0 || bus.M1 !== e[k]) begin
                fails++;
                $display("FAIL lookup_hold_%0d got v=%b M1=%b exp 0 %b",
                         a[k], bus.out_valid, bus.M1, e[k]);
            end
        end
    endtask

    task automatic test_early_last();
        int cyc;
        bit early;
        for (int i = 0; i < 64; i++) pat[i] = 2'($urandom_range(0, 3));
        drive_load(11, 10, 0, cyc, early);
        tests++;
        if (bus.cfg_err !== 1'b1 || bus.loaded !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL early_last got err=%b loaded=%b rdy=%b exp 1 0 0",
                     bus.cfg_err, bus.loaded, bus.cfg_ready);
        end
        bus.in_valid = 1'b1;
        bus.M0 = 6'd1;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_last_lookup got out_valid=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_no_last();
        int cyc;
        bit early;
        for (int i = 0; i < 64; i++) pat[i] = 2'($urandom_range(0, 3));
        drive_load(64, -1, 0, cyc, early);
        tests++;
        if (bus.cfg_err !== 1'b1 || bus.loaded !== 1'b0) begin
            fails++;
            $display("FAIL no_last got err=%b loaded=%b exp 1 0",
                     bus.cfg_err, bus.loaded);
        end
    endtask

    task automatic test_gapped_load();
        int cyc;
        bit early;
        for (int i = 0; i < 64; i++) pat[i] = 2'($urandom_range(0, 3));
        drive_load(64, 63, 1, cyc, early);
        for (int i = 0; i < 64; i++) ref_tbl[i] = pat[i];
        tests++;
        if (bus.loaded !== 1'b1 || bus.cfg_err !== 1'b0 || early || cyc !== 127) begin
            fails++;
            $display("FAIL gapped_load got loaded=%b err=%b early=%b cyc=%0d exp 1 0 0 127",
                     bus.loaded, bus.cfg_err, early, cyc);
        end
    endtask

    task automatic test_back_to_back(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            bus.in_valid = 1'b1;
            bus.M0 = 6'(i);
            tick();
            if (bus.out_valid !== 1'b1 || bus.M1 !== ref_tbl[i]) begin
                if (bad == 0)
                    $display("FAIL %s_sweep at %0d got v=%b M1=%b exp 1 %b",
                             tag, i, bus.out_valid, bus.M1, ref_tbl[i]);
                bad++;
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (bad != 0) fails++;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.M1 !== ref_tbl[63]) begin
            fails++;
            $display("FAIL %s_sweep_end got v=%b M1=%b exp 0 %b",
                     tag, bus.out_valid, bus.M1, ref_tbl[63]);
        end
    endtask

    task automatic test_random_lookup();
        logic [1:0] exp_m1;
        logic [5:0] a;
        bit v;
        int bad;
        bad = 0;
        exp_m1 = bus.M1;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 1));
            a = 6'($urandom_range(0, 63));
            bus.in_valid = v;
            bus.M0 = a;
            tick();
            if (v) exp_m1 = ref_tbl[a];
            if (bus.out_valid !== v || bus.M1 !== exp_m1) begin
                if (bad == 0)
                    $display("FAIL random_lookup step %0d got v=%b M1=%b exp %b %b",
                             i, bus.out_valid, bus.M1, v, exp_m1);
                bad++;
            end
        end
        bus.in_valid = 1'b0;
        tick();
        tests++;
        if (bad != 0) fails++;
    endtask

    task automatic test_restart_in_run();
        bus.cfg_start = 1'b1;
        bus.in_valid = 1'b1;
        bus.M0 = 6'd3;
        tick();
        bus.cfg_start = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.loaded !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL restart_run got loaded=%b rdy=%b v=%b exp 0 1 0",
                     bus.loaded, bus.cfg_ready, bus.out_valid);
        end
    endtask

    task automatic test_rst_midload();
        int cyc;
        bit early;
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.cfg_valid = 1'b1;
            bus.cfg_data = 2'($urandom_range(0, 3));
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.cfg_ready, bus.cfg_err, bus.loaded, bus.out_valid, bus.M1} !== 6'b0) begin
            fails++;
            $display("FAIL rst_midload got %b exp 000000",
                     {bus.cfg_ready, bus.cfg_err, bus.loaded, bus.out_valid, bus.M1});
        end
        bus.cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 64; i++) pat[i] = ~2'(i);
        drive_load(64, 63, 0, cyc, early);
        for (int i = 0; i < 64; i++) ref_tbl[i] = pat[i];
        tests++;
        if (bus.loaded !== 1'b1 || bus.cfg_err !== 1'b0) begin
            fails++;
            $display("FAIL reload got loaded=%b err=%b exp 1 0", bus.loaded, bus.cfg_err);
        end
`ifdef LUT_READBACK_EN
        bus.rb_addr = 6'd5;
        tick();
        tests++;
        if (bus.rb_data !== 2'b10) begin
            fails++;
            $display("FAIL readback got %b exp 10", bus.rb_data);
        end
`endif
    endtask

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.M0        = '0;
`ifdef LUT_READBACK_EN
        bus.rb_addr   = '0;
`endif
        test_reset();
        test_full_load();
        test_early_last();
        test_no_last();
        test_gapped_load();
        test_back_to_back("gapped");
        test_random_lookup();
        test_restart_in_run();
        test_rst_midload();
        test_back_to_back("reload");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
